// File: rtl/had_job_scheduler.sv
// had_job_scheduler: queues half-filled requests and runs the Hadamard engine one half at a time
module had_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 err_clr,
  output logic [31:0]          ps_control,
  input  logic [31:0]          pl_status,
  output logic                 done_a,
  output logic                 done_b,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] overrun_count,
  output logic                 timeout_err
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
  state_t               state_q;
  logic                 job_q;
  logic [1:0]           q_q, q_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [TW-1:0]        tmr_q;
  logic [1:0]           ps_q;
  logic                 done_a_q, done_b_q, err_q;
  logic [CNT_WIDTH-1:0] ovr_q, ovr_d;
  logic [CNT_WIDTH:0]   ovr_sum;
  logic [1:0]           drops, n0, n1;
  logic                 active, queued_a, queued_b, acc_a, acc_b, pop, st_job, job_done, job_to;
  logic                 unused_status;
  assign unused_status = ^pl_status[31:2];
  assign active   = state_q != IDLE;
  assign queued_a = (cnt_q != 2'd0 && !q_q[0]) || (cnt_q == 2'd2 && !q_q[1]);
  assign queued_b = (cnt_q != 2'd0 && q_q[0]) || (cnt_q == 2'd2 && q_q[1]);
  // the running job stays "current" until IDLE is re-entered, so repeats are dropped
  assign acc_a    = req_a && !queued_a && !(active && !job_q);
  assign acc_b    = req_b && !queued_b && !(active && job_q);
  assign drops    = {1'b0, req_a && !acc_a} + {1'b0, req_b && !acc_b};
  assign ovr_sum  = {1'b0, ovr_q} + (CNT_WIDTH+1)'(drops);
  assign ovr_d    = ovr_sum[CNT_WIDTH] ? '1 : ovr_sum[CNT_WIDTH-1:0];
  assign pop      = !active && enable && cnt_q != 2'd0;
  assign st_job   = pl_status[job_q];
  assign job_done = state_q == RUN && st_job;
  assign job_to   = state_q == RUN && !st_job && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  // pop first, then append A ahead of B
  always_comb begin
    n0 = cnt_q - {1'b0, pop};
    q_d = pop ? {1'b0, q_q[1]} : q_q;
    n1 = n0 + {1'b0, acc_a};
    if (acc_a) q_d[n0[0]] = 1'b0;
    if (acc_b) q_d[n1[0]] = 1'b1;
    cnt_d = n1 + {1'b0, acc_b};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      job_q    <= 1'b0;
      q_q      <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      ps_q     <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      ovr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      done_a_q <= job_done && !job_q;
      done_b_q <= job_done && job_q;
      err_q    <= job_to || (err_q && !err_clr);
      case (state_q)
        IDLE: if (pop) begin
          state_q <= RUN;
          job_q   <= q_q[0];
          tmr_q   <= '0;
          ps_q    <= q_q[0] ? 2'b10 : 2'b01;
        end
        RUN: if (job_done || job_to) begin
          state_q <= RELEASE;
          ps_q    <= '0;
        end else tmr_q <= tmr_q + 1'b1;
        RELEASE: if (!st_job) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ps_control    = {30'b0, ps_q};
  assign done_a        = done_a_q;
  assign done_b        = done_b_q;
  assign busy          = active || cnt_q != 2'd0;
  assign overrun_count = ovr_q;
  assign timeout_err   = err_q;
endmodule

// File: tb/tb_had_job_scheduler.sv
// tb_had_job_scheduler: directed checks of the scheduler against a simple engine model
module tb_had_job_scheduler;
  localparam int TO = 1024;
  logic        clk = 1'b0;
  logic        reset, enable, req_a, req_b, err_clr;
  logic [31:0] ps_control, pl_status;
  logic        done_a, done_b, busy, timeout_err;
  logic [3:0]  overrun_count;
  int          checks = 0, failures = 0, da_n = 0, db_n = 0, lat = 514, sa, sb;
  logic        eng_off = 1'b0;
  logic [1:0]  run = 2'b00, comp = 2'b00;
  int          ecnt [2];

  always #5 clk = ~clk;
  assign pl_status = {30'b0, comp};

  had_job_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_a(req_a), .req_b(req_b),
    .err_clr(err_clr), .ps_control(ps_control), .pl_status(pl_status),
    .done_a(done_a), .done_b(done_b), .busy(busy),
    .overrun_count(overrun_count), .timeout_err(timeout_err)
  );

  always @(posedge clk) begin
    if (done_a) da_n <= da_n + 1;
    if (done_b) db_n <= db_n + 1;
  end

  // engine: completes lat cycles after start, clears completed one cycle after start is low
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (run[i]) begin
        if (ecnt[i] >= lat) begin
          comp[i] <= 1'b1;
          run[i]  <= 1'b0;
        end else ecnt[i] <= ecnt[i] + 1;
      end else if (ps_control[i] && !comp[i] && !eng_off) begin
        run[i]  <= 1'b1;
        ecnt[i] <= 1;
      end
      if (comp[i] && !ps_control[i]) comp[i] <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; req_a = 1'b0; req_b = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_ps", ps_control, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'({done_a, done_b}), 32'h0);
    chk("rst_ovr", 32'(overrun_count), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    tick();
    // single A job
    sa = da_n;
    req_a = 1'b1; tick(); req_a = 1'b0;
    chk("a_queued_ps", ps_control, 32'h0);
    chk("a_queued_busy", 32'(busy), 32'h1);
    tick();
    chk("a_start", ps_control, 32'h1);
    for (int i = 0; i < 700 && comp[0] !== 1'b1; i++) tick();
    chk("a_comp_seen", 32'(comp[0]), 32'h1);
    chk("a_ps_hold", ps_control, 32'h1);
    tick();
    chk("a_done", 32'(done_a), 32'h1);
    chk("a_ps_rel", ps_control, 32'h0);
    chk("a_status_high", 32'(comp[0]), 32'h1);
    tick();
    chk("a_done_once", 32'(done_a), 32'h0);
    chk("a_busy_rel", 32'(busy), 32'h1);
    tick();
    chk("a_idle", 32'(busy), 32'h0);
    chk("a_count", 32'(da_n - sa), 32'h1);
    chk("a_ovr", 32'(overrun_count), 32'h0);
    // simultaneous A and B
    sa = da_n; sb = db_n;
    req_a = 1'b1; req_b = 1'b1; tick(); req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("sim_first", ps_control, 32'h1);
    for (int i = 0; i < 700 && done_a !== 1'b1; i++) tick();
    chk("sim_done_a", 32'(done_a), 32'h1);
    chk("sim_no_b_yet", 32'(db_n - sb), 32'h0);
    for (int i = 0; i < 10 && ps_control === 32'h0; i++) tick();
    chk("sim_second", ps_control, 32'h2);
    chk("sim_a_low", 32'(comp[0]), 32'h0);
    for (int i = 0; i < 700 && done_b !== 1'b1; i++) tick();
    chk("sim_done_b", 32'(done_b), 32'h1);
    chk("sim_a_count", 32'(da_n - sa), 32'h1);
    for (int i = 0; i < 10 && busy !== 1'b0; i++) tick();
    tick();
    chk("sim_b_count", 32'(db_n - sb), 32'h1);
    // overrun while queued and while running
    sa = da_n;
    req_a = 1'b1; tick(); tick(); req_a = 1'b0;
    chk("ovr_queued", 32'(overrun_count), 32'h1);
    chk("ovr_run_ps", ps_control, 32'h1);
    tick(); tick(); tick();
    req_a = 1'b1; tick(); req_a = 1'b0;
    chk("ovr_run", 32'(overrun_count), 32'h2);
    for (int i = 0; i < 700 && busy !== 1'b0; i++) tick();
    tick();
    chk("ovr_one_job", 32'(da_n - sa), 32'h1);
    chk("ovr_idle_ps", ps_control, 32'h0);
    // saturation with double drops
    enable = 1'b0;
    req_a = 1'b1; req_b = 1'b1; tick();
    chk("ovr_both_acc", 32'(overrun_count), 32'h2);
    for (int i = 0; i < 6; i++) tick();
    chk("ovr_14", 32'(overrun_count), 32'd14);
    tick();
    chk("ovr_sat", 32'(overrun_count), 32'd15);
    tick();
    chk("ovr_sat_hold", 32'(overrun_count), 32'd15);
    req_a = 1'b0; req_b = 1'b0;
    chk("ovr_hold_ps", ps_control, 32'h0);
    enable = 1'b1;
    for (int i = 0; i < 1500 && busy !== 1'b0; i++) tick();
    chk("ovr_drain", 32'(busy), 32'h0);
    // timeout on B with A queued behind it
    eng_off = 1'b1; sa = da_n; sb = db_n;
    req_b = 1'b1; tick(); req_b = 1'b0;
    tick();
    chk("to_start", ps_control, 32'h2);
    req_a = 1'b1; tick(); req_a = 1'b0;
    for (int i = 0; i < TO - 2; i++) tick();
    chk("to_before_ps", ps_control, 32'h2);
    chk("to_before_err", 32'(timeout_err), 32'h0);
    tick();
    chk("to_ps", ps_control, 32'h0);
    chk("to_err", 32'(timeout_err), 32'h1);
    eng_off = 1'b0;
    tick();
    chk("to_busy_q", 32'(busy), 32'h1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_next", ps_control, 32'h1);
    chk("to_clr", 32'(timeout_err), 32'h0);
    for (int i = 0; i < 700 && busy !== 1'b0; i++) tick();
    tick();
    chk("to_no_b", 32'(db_n - sb), 32'h0);
    chk("to_a_ran", 32'(da_n - sa), 32'h1);
    // enable gating
    enable = 1'b0; sb = db_n;
    req_b = 1'b1; tick(); req_b = 1'b0;
    tick(); tick();
    chk("en_hold_ps", ps_control, 32'h0);
    chk("en_hold_busy", 32'(busy), 32'h1);
    enable = 1'b1; tick();
    chk("en_start", ps_control, 32'h2);
    for (int i = 0; i < 700 && busy !== 1'b0; i++) tick();
    tick();
    chk("en_b_done", 32'(db_n - sb), 32'h1);
    // reset mid-RUN
    sa = da_n;
    req_a = 1'b1; tick(); req_a = 1'b0;
    tick();
    chk("rr_run", ps_control, 32'h1);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rr_ps", ps_control, 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_ovr", 32'(overrun_count), 32'h0);
    chk("rr_err", 32'(timeout_err), 32'h0);
    for (int i = 0; i < 700 && comp[0] !== 1'b1; i++) tick();
    chk("rr_late", 32'(comp[0]), 32'h1);
    tick(); tick();
    chk("rr_fell", 32'(comp[0]), 32'h0);
    chk("rr_no_done", 32'(da_n - sa), 32'h0);
    chk("rr_idle", 32'(busy), 32'h0);
    req_a = 1'b1; tick(); req_a = 1'b0;
    tick();
    chk("rr_fresh", ps_control, 32'h1);
    for (int i = 0; i < 700 && busy !== 1'b0; i++) tick();
    tick();
    chk("rr_fresh_done", 32'(da_n - sa), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
